// File: rtl/instr_fetch.sv
// Fetch stage between the PC and decode: issues one imem request per PC value,
// delivers {instr, pc} through a valid/ready IF/ID register with a one-entry skid.
module instr_fetch #(
  parameter int                 ADDR_W  = 8,
  parameter int                 INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP     = 16'h0000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               pc_en,
  input  logic               branch_taken,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
);

  // state | meaning
  // FETCH | sample pc_addr and issue a request unless a branch is redirecting
  // WAIT  | request outstanding, waiting for imem_ack (kill drops the response)
  // HOLD  | response parked in skid because IF/ID was full, nothing outstanding
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                kill, kill_nxt;
  logic                req_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                pc_en_nxt;
  logic                valid_nxt;
  logic [INSTR_W-1:0]  instr_nxt;
  logic [ADDR_W-1:0]   id_pc_nxt;
  logic [INSTR_W-1:0]  skid_instr, skid_instr_nxt;
  logic [ADDR_W-1:0]   skid_pc, skid_pc_nxt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_FETCH;
      kill       <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      pc_en      <= 1'b0;
      id_valid   <= 1'b0;
      id_instr   <= NOP;
      id_pc      <= '0;
      skid_instr <= NOP;
      skid_pc    <= '0;
    end else begin
      state      <= state_nxt;
      kill       <= kill_nxt;
      imem_req   <= req_nxt;
      imem_addr  <= addr_nxt;
      pc_en      <= pc_en_nxt;
      id_valid   <= valid_nxt;
      id_instr   <= instr_nxt;
      id_pc      <= id_pc_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc    <= skid_pc_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    kill_nxt       = kill;
    req_nxt        = imem_req;
    addr_nxt       = imem_addr;
    pc_en_nxt      = 1'b0;
    valid_nxt      = id_valid;
    instr_nxt      = id_instr;
    id_pc_nxt      = id_pc;
    skid_instr_nxt = skid_instr;
    skid_pc_nxt    = skid_pc;

    // Consumption without a reload leaves id_instr at its old value.
    if (id_valid && id_ready) valid_nxt = 1'b0;

    case (state)
      S_FETCH: begin
        if (!branch_taken) begin
          addr_nxt  = pc_addr;
          req_nxt   = 1'b1;
          pc_en_nxt = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = S_FETCH;
          if (kill || branch_taken) begin
            kill_nxt = 1'b0;
          end else if (!id_valid || id_ready) begin
            instr_nxt = imem_data;
            id_pc_nxt = imem_addr;
            valid_nxt = 1'b1;
          end else begin
            skid_instr_nxt = imem_data;
            skid_pc_nxt    = imem_addr;
            state_nxt      = S_HOLD;
          end
        end else if (branch_taken) begin
          kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          state_nxt = S_FETCH;
        end else if (id_ready) begin
          instr_nxt = skid_instr;
          id_pc_nxt = skid_pc;
          valid_nxt = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase

    // A redirect wins over any load into IF/ID in the same cycle.
    if (branch_taken) begin
      valid_nxt = 1'b0;
      instr_nxt = NOP;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, checked against
// an in-order queue model of delivered {pc, instr} plus request-protocol rules.
module tb_instr_fetch;

  localparam logic [15:0] NOP = 16'h0000;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } ent_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  pc_addr;
  logic        pc_en;
  logic        branch_taken;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;

  instr_fetch dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .pc_addr      (pc_addr),
    .pc_en        (pc_en),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .id_ready     (id_ready),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc        (id_pc)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad = 0;
  int          delivered = 0;
  logic [15:0] mem [256];
  logic [7:0]  pc;
  ent_t        q[$];
  bit          killed;
  bit          p_req, p_ack, p_br, p_valid;
  logic [7:0]  p_addr, p_pc;
  logic [15:0] p_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid_model", 32'(id_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("instr_model", 32'(id_instr), 32'(q[0].instr));
      chk("pc_model", 32'(id_pc), 32'(q[0].pc));
    end
    chk("pc_en", 32'(pc_en), 32'(imem_req && !p_req));
    if (p_req && !p_ack) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", 32'(imem_addr), 32'(p_addr));
    end
    if (p_req && p_ack) chk("req_drop", 32'(imem_req), 32'd0);
    if (imem_req && !p_req) begin
      chk("issue_addr", 32'(imem_addr), 32'(p_pc));
      chk("issue_nobr", 32'(p_br), 32'd0);
    end
    if (p_br) chk("br_nop", 32'(id_instr), 32'(NOP));
    else if (!id_valid) chk("instr_hold", 32'(id_instr), 32'(p_instr));
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic step(input bit ack, input bit rdy, input bit br, input logic [7:0] tgt);
    ent_t e;
    imem_ack     = ack;
    id_ready     = rdy;
    branch_taken = br;
    imem_data    = mem[imem_addr];
    if (id_valid && rdy && q.size() != 0) begin
      void'(q.pop_front());
      delivered++;
    end
    if (br) begin
      q.delete();
      killed = imem_req && !ack;
    end else if (imem_req && ack) begin
      if (!killed) begin
        e.pc    = imem_addr;
        e.instr = mem[imem_addr];
        q.push_back(e);
      end
      killed = 1'b0;
    end
    p_req = imem_req; p_addr = imem_addr; p_ack = ack; p_br = br;
    p_pc = pc_addr; p_valid = id_valid; p_instr = id_instr;
    if (br) pc = tgt;
    else if (pc_en) pc = pc + 8'd1;
    @(posedge CLK);
    @(negedge CLK);
    pc_addr      = pc;
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    RST_N = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; id_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    q.delete(); killed = 1'b0;
    p_req = 1'b0; p_ack = 1'b0; p_br = 1'b0; p_valid = 1'b0; p_instr = NOP;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_instr", 32'(id_instr), 32'(NOP));
    chk("rst_id_pc", 32'(id_pc), 32'd0);
    RST_N = 1'b1;
  endtask

  initial begin
    int nval;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[5] = 16'hDEAD;
    pc = 8'h00; pc_addr = 8'h00; imem_data = 16'h0;
    RST_N = 1'b0; imem_ack = 1'b0; branch_taken = 1'b0; id_ready = 1'b0;
    @(negedge CLK);
    do_reset();

    // first fetch and steady-state throughput
    step(0, 1, 0, 8'h00);
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    chk("t1_pc_en", 32'(pc_en), 32'd1);
    step(1, 1, 0, 8'h00);
    chk("t1_valid", 32'(id_valid), 32'd1);
    chk("t1_instr", 32'(id_instr), 32'h1234);
    chk("t1_id_pc", 32'(id_pc), 32'd0);
    nval = 0;
    for (int i = 0; i < 8; i++) begin
      step(bit'(i % 2), 1, 0, 8'h00);
      nval += int'(id_valid);
    end
    chk("t1_throughput", 32'(nval), 32'd4);

    // memory stall at 0x03
    pc = 8'h03; pc_addr = 8'h03;
    step(0, 1, 0, 8'h00);
    chk("t2_issue", 32'(imem_addr), 32'h03);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h00);
      chk("t2_req", 32'(imem_req), 32'd1);
      chk("t2_addr", 32'(imem_addr), 32'h03);
      chk("t2_pc_en", 32'(pc_en), 32'd0);
    end
    step(1, 1, 0, 8'h00);
    chk("t2_instr", 32'(id_instr), 32'(mem[3]));
    chk("t2_id_pc", 32'(id_pc), 32'h03);

    // skid: A = mem[3] held, B = mem[4] parked
    step(0, 0, 0, 8'h00);
    chk("t3_issue", 32'(imem_addr), 32'h04);
    step(1, 0, 0, 8'h00);
    chk("t3_req", 32'(imem_req), 32'd0);
    chk("t3_keep_a", 32'(id_instr), 32'(mem[3]));
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 8'h00);
      chk("t3_hold_req", 32'(imem_req), 32'd0);
    end
    step(0, 1, 0, 8'h00);
    chk("t3_b_instr", 32'(id_instr), 32'(mem[4]));
    chk("t3_b_pc", 32'(id_pc), 32'h04);
    chk("t3_b_valid", 32'(id_valid), 32'd1);
    step(0, 1, 0, 8'h00);
    chk("t3_resume", 32'(imem_req), 32'd1);
    chk("t3_resume_addr", 32'(imem_addr), 32'h05);

    // branch during WAIT at 0x05, late ack carrying 0xDEAD
    step(0, 1, 1, 8'h40);
    chk("t4_valid", 32'(id_valid), 32'd0);
    chk("t4_nop", 32'(id_instr), 32'(NOP));
    step(0, 1, 0, 8'h00);
    chk("t4_addr", 32'(imem_addr), 32'h05);
    step(1, 1, 0, 8'h00);
    chk("t4_drop_valid", 32'(id_valid), 32'd0);
    chk("t4_drop_instr", 32'(id_instr), 32'(NOP));
    step(0, 1, 0, 8'h00);
    chk("t4_redirect", 32'(imem_addr), 32'h40);

    // branch and ack together, then branch in HOLD
    step(1, 1, 1, 8'h20);
    chk("t5_req", 32'(imem_req), 32'd0);
    chk("t5_valid", 32'(id_valid), 32'd0);
    step(0, 1, 0, 8'h00);
    chk("t5_issue", 32'(imem_addr), 32'h20);
    step(1, 1, 0, 8'h00);
    chk("t5_load", 32'(id_instr), 32'(mem[8'h20]));
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    chk("t5_hold_req", 32'(imem_req), 32'd0);
    step(0, 0, 1, 8'h60);
    chk("t5_hold_valid", 32'(id_valid), 32'd0);
    chk("t5_hold_nop", 32'(id_instr), 32'(NOP));
    step(0, 1, 0, 8'h00);
    chk("t5_after_hold", 32'(imem_addr), 32'h60);
    step(1, 1, 0, 8'h00);
    chk("t5_after_instr", 32'(id_instr), 32'(mem[8'h60]));

    // reset while a request is outstanding, then a stray ack
    step(0, 1, 0, 8'h00);
    chk("t6_req", 32'(imem_req), 32'd1);
    do_reset();
    step(1, 1, 0, 8'h00);
    chk("t6_late_ack", 32'(id_valid), 32'd0);
    step(0, 1, 0, 8'h00);
    chk("t6_still", 32'(id_valid), 32'd0);

    // random traffic
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      step(bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 11) == 0), 8'($urandom));
    end
    chk("rand_progress", 32'(delivered > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
